// File: rtl/e_dff.sv
// rtl/e_dff.sv - enable-gated D flip-flop cell with asynchronous active-low reset
module e_dff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Recirculating mux instead of a gated clock keeps the cell a plain DFF.
  logic [WIDTH-1:0] q_next;

  assign q_next = en ? d : q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_e_dff.sv
// tb/tb_e_dff.sv - randomized and directed bench for e_dff against a behavioural cell model
module tb_e_dff;

  localparam logic [7:0] RV8 = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en;
  logic        d1, q1;
  logic [63:0] d64, q64;
  logic [7:0]  d8, q8;

  always #5 clk = ~clk;

  e_dff u_dff1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .en    (en),
    .q     (q1)
  );

  e_dff #(.WIDTH(64)) u_dff64 (
    .clk   (clk),
    .reset (reset),
    .d     (d64),
    .en    (en),
    .q     (q64)
  );

  e_dff #(.WIDTH(8), .RESET_VAL(RV8)) u_dff8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .en    (en),
    .q     (q8)
  );

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  // Model: each cell holds the value of its most recent enabled capture since reset.
  logic        m1;
  logic [63:0] m64;
  logic [7:0]  m8;

  always @(posedge clk or negedge reset) begin
    if (reset !== 1'b1) begin
      m1  = 1'b0;
      m64 = '0;
      m8  = RV8;
    end else if (en) begin
      m1  = d1;
      m64 = d64;
      m8  = d8;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("model_q1", {63'd0, q1}, {63'd0, m1});
      check("model_q64", q64, m64);
      check("model_q8", {56'd0, q8}, {56'd0, m8});
    end
  end

  initial begin
    en  = 1'b1;
    d1  = 1'b1;
    d64 = '1;
    d8  = '1;
    #1 reset = 1'b0;
    armed = 1'b1;

    // reset holds the cells cleared across enabled edges
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_q1", {63'd0, q1}, 64'd0);
      check("rst_q64", q64, 64'd0);
      check("rst_q8", {56'd0, q8}, {56'd0, RV8});
      check("rst_model8", {56'd0, m8}, 64'h00000000000000A5);
    end

    @(negedge clk);
    reset = 1'b1;
    d1 = 1'b0;
    d8 = 8'h00;

    // one-hot walk across the wide cell
    for (int i = 0; i < 64; i++) begin
      d64 = 64'd1 << i;
      @(posedge clk);
      #1;
      check("walk_q64", q64, 64'd1 << i);
      @(negedge clk);
    end

    // hold while disabled
    d1 = 1'b1;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    d1 = 1'b0;
    d64 = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_q1", {63'd0, q1}, 64'd1);
      check("hold_q64", q64, 64'h8000000000000000);
    end

    // enable toggling: every enabled edge sees d=1
    @(negedge clk);
    en = 1'b1;
    d1 = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = (k % 2 == 0);
      d1 = (k % 2 == 0);
      @(posedge clk);
      #1;
      check("toggle_q1", {63'd0, q1}, 64'd1);
    end

    // asynchronous reset 2 ns after an edge
    @(negedge clk);
    en = 1'b1;
    d1 = 1'b1;
    d8 = 8'h3C;
    @(posedge clk);
    #1;
    check("pre_async_q1", {63'd0, q1}, 64'd1);
    #1 reset = 1'b0;
    #1;
    check("async_q1", {63'd0, q1}, 64'd0);
    check("async_q8", {56'd0, q8}, {56'd0, RV8});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_async_q8", {56'd0, q8}, 64'h3C);

    // reset asserted coincident with an enabled edge
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("edge_rst_q1", {63'd0, q1}, 64'd0);
    check("edge_rst_q8", {56'd0, q8}, {56'd0, RV8});
    @(posedge clk);
    #1;
    check("edge_rst_hold_q1", {63'd0, q1}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("edge_rst_release_q1", {63'd0, q1}, 64'd1);

    // randomized traffic with occasional mid-cycle reset pulses
    repeat (400) begin
      @(negedge clk);
      en  = 1'($urandom);
      d1  = 1'($urandom);
      d64 = {$urandom, $urandom};
      d8  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rand_async_q64", q64, 64'd0);
        check("rand_async_q8", {56'd0, q8}, {56'd0, RV8});
        #4 reset = 1'b1;
      end
    end

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
